// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error
// codes and the controller state enum.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_SIZE     = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_READ = 2'd2,
      RESPOND   = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane_extract.sv
// Combinational load-lane extraction: shift the addressed bytes down to bit 0,
// then sign- or zero-extend from 8/16/32 bits. Dword loads pass through.
module lane_extract
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input  logic [WORD_SIZE-1:0]           data,
   input  logic [$clog2(WORD_SIZE/8)-1:0] offset,
   input  logic [1:0]                     size,
   input  logic                           is_unsigned,
   output logic [WORD_SIZE-1:0]           result
);

   logic [WORD_SIZE-1:0] shifted;
   logic [WORD_SIZE-1:0] mask;
   logic                 sign;

   // A full-width word load keeps mask all ones, so it passes unchanged.
   always_comb begin
      shifted = data >> {offset, 3'b000};
      mask    = '1;
      sign    = 1'b0;
      case (size)
         SIZE_B: begin
            mask = {WORD_SIZE{1'b1}} >> (WORD_SIZE - 8);
            sign = shifted[7];
         end
         SIZE_H: begin
            mask = {WORD_SIZE{1'b1}} >> (WORD_SIZE - 16);
            sign = shifted[15];
         end
         SIZE_W: begin
            mask = {WORD_SIZE{1'b1}} >> (WORD_SIZE - 32);
            sign = shifted[31];
         end
         default: ;
      endcase
      result = (shifted & mask) | ({WORD_SIZE{sign & ~is_unsigned}} & ~mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment/size checking, byte-lane
// steering, valid/ready memory port with byte enables and a bus timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE      = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [WORD_SIZE-1:0]   req_wdata,
   input  logic                   req_is_store,
   input  logic [1:0]             req_size,
   input  logic                   req_unsigned,
   output logic                   resp_valid,
   output logic [WORD_SIZE-1:0]   resp_data,
   output logic [1:0]             resp_error,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_we,
   output logic [WORD_SIZE/8-1:0] mem_be,
   output logic [WORD_SIZE-1:0]   mem_wdata,
   input  logic                   mem_rvalid,
   input  logic [WORD_SIZE-1:0]   mem_rdata,
   output lsu_state_e             dbg_state
);

   localparam int BYTES = WORD_SIZE / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   lsu_state_e            state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_SIZE-1:0]  wdata_q;
   logic [WORD_SIZE-1:0]  resp_data_q;
   logic [WORD_SIZE-1:0]  rdata_ext;
   logic                  store_q;
   logic                  unsigned_q;
   logic [1:0]            size_q;
   logic [1:0]            resp_error_q;
   logic [1:0]            req_err;
   logic [CNT_W-1:0]      tmo_cnt;
   logic                  tmo_hit;
   logic [OFF_W-1:0]      offset;
   logic [7:0]            size_mask;
   logic [BYTES-1:0]      be;

   always_comb begin
      req_err = ERR_NONE;
      if (req_size == SIZE_D && WORD_SIZE == 32) begin
         req_err = ERR_SIZE;
      end else begin
         case (req_size)
            SIZE_H:  if (req_addr[0])        req_err = ERR_MISALIGN;
            SIZE_W:  if (|req_addr[1:0])     req_err = ERR_MISALIGN;
            SIZE_D:  if (|req_addr[2:0])     req_err = ERR_MISALIGN;
            default: ;
         endcase
      end
   end

   // Counter stays cleared outside the bus phase, so it reads zero on ISSUE entry.
   assign tmo_hit = TMO_EN && (tmo_cnt >= CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (req_valid) state_nxt = (req_err == ERR_NONE) ? ISSUE : RESPOND;
         ISSUE: begin
            if (mem_ready)    state_nxt = store_q ? RESPOND : WAIT_READ;
            else if (tmo_hit) state_nxt = RESPOND;
         end
         WAIT_READ: if (mem_rvalid || tmo_hit) state_nxt = RESPOND;
         RESPOND:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         store_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         size_q       <= SIZE_B;
         resp_data_q  <= '0;
         resp_error_q <= ERR_NONE;
         tmo_cnt      <= '0;
      end else begin
         if (state != ISSUE && state != WAIT_READ) tmo_cnt <= '0;
         else if (TMO_EN)                          tmo_cnt <= tmo_cnt + CNT_W'(1);
         case (state)
            IDLE: if (req_valid) begin
               addr_q       <= req_addr;
               wdata_q      <= req_wdata;
               store_q      <= req_is_store;
               unsigned_q   <= req_unsigned;
               size_q       <= req_size;
               resp_data_q  <= '0;
               resp_error_q <= req_err;
            end
            ISSUE: if (!mem_ready && tmo_hit) resp_error_q <= ERR_TIMEOUT;
            WAIT_READ: begin
               if (mem_rvalid)   resp_data_q  <= rdata_ext;
               else if (tmo_hit) resp_error_q <= ERR_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   assign offset = addr_q[OFF_W-1:0];

   always_comb begin
      case (size_q)
         SIZE_B:  size_mask = 8'h01;
         SIZE_H:  size_mask = 8'h03;
         SIZE_W:  size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      be = BYTES'(size_mask) << offset;
   end

   // Replicate store data across lanes so the bus data never depends on offset.
   always_comb begin
      case (size_q)
         SIZE_B:  mem_wdata = {BYTES{wdata_q[7:0]}};
         SIZE_H:  mem_wdata = {(BYTES/2){wdata_q[15:0]}};
         SIZE_W:  mem_wdata = {(WORD_SIZE/32){wdata_q[31:0]}};
         default: mem_wdata = wdata_q;
      endcase
   end

   lane_extract #(.WORD_SIZE(WORD_SIZE)) u_lane_extract (
      .data        (mem_rdata),
      .offset      (offset),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .result      (rdata_ext)
   );

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESPOND);
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;
   assign mem_valid  = (state == ISSUE);
   assign mem_we     = mem_valid & store_q;
   assign mem_be     = mem_valid ? be : '0;
   assign mem_addr   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance (long timeout) and a 64-bit
// instance (timeout 4) share request/bus inputs; sel picks the one observed.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        sel, req_valid, req_is_store, req_unsigned, mem_ready, mem_rvalid;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, mem_rdata;
   logic [1:0]  req_size;

   logic        req_ready_a, resp_valid_a, mem_valid_a, mem_we_a;
   logic [31:0] resp_data_a, mem_addr_a, mem_wdata_a;
   logic [1:0]  resp_error_a;
   logic [3:0]  mem_be_a;
   lsu_state_e  dbg_state_a;

   logic        req_ready_b, resp_valid_b, mem_valid_b, mem_we_b;
   logic [63:0] resp_data_b, mem_wdata_b;
   logic [31:0] mem_addr_b;
   logic [1:0]  resp_error_b;
   logic [7:0]  mem_be_b;
   lsu_state_e  dbg_state_b;

   load_store_unit #(.WORD_SIZE(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_is_store(req_is_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid_a),
      .resp_data(resp_data_a), .resp_error(resp_error_a), .mem_valid(mem_valid_a),
      .mem_ready(mem_ready), .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_be(mem_be_a),
      .mem_wdata(mem_wdata_a), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
      .dbg_state(dbg_state_a)
   );

   load_store_unit #(.WORD_SIZE(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(req_ready_b),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_is_store(req_is_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid_b),
      .resp_data(resp_data_b), .resp_error(resp_error_b), .mem_valid(mem_valid_b),
      .mem_ready(mem_ready), .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_be(mem_be_b),
      .mem_wdata(mem_wdata_b), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state_b)
   );

   logic        req_ready_s, resp_valid_s, mem_valid_s, mem_we_s;
   logic [63:0] resp_data_s, mem_wdata_s;
   logic [31:0] mem_addr_s;
   logic [1:0]  resp_error_s;
   logic [7:0]  mem_be_s;
   lsu_state_e  dbg_state_s;

   assign req_ready_s  = sel ? req_ready_b  : req_ready_a;
   assign resp_valid_s = sel ? resp_valid_b : resp_valid_a;
   assign mem_valid_s  = sel ? mem_valid_b  : mem_valid_a;
   assign mem_we_s     = sel ? mem_we_b     : mem_we_a;
   assign resp_data_s  = sel ? resp_data_b  : {32'b0, resp_data_a};
   assign mem_wdata_s  = sel ? mem_wdata_b  : {32'b0, mem_wdata_a};
   assign mem_addr_s   = sel ? mem_addr_b   : mem_addr_a;
   assign resp_error_s = sel ? resp_error_b : resp_error_a;
   assign mem_be_s     = sel ? mem_be_b     : {4'b0, mem_be_a};
   assign dbg_state_s  = sel ? dbg_state_b  : dbg_state_a;

   int n_vec = 0;
   int n_err = 0;
   logic [65:0] exp_q[$];

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (resp_valid_s) begin
         if (exp_q.size() == 0) check("spurious_resp", resp_valid_s, 1'b0);
         else check("resp", {resp_error_s, resp_data_s}, exp_q.pop_front());
      end
   end

   function automatic logic [63:0] model_load(input logic [63:0] rd, input int off,
                                              input logic [1:0] sz, input logic un, input int w);
      logic [63:0] s, v;
      s = rd >> (8 * off);
      case (sz)
         2'd0:    v = un ? 64'(s[7:0])  : 64'($signed(s[7:0]));
         2'd1:    v = un ? 64'(s[15:0]) : 64'($signed(s[15:0]));
         2'd2:    v = un ? 64'(s[31:0]) : 64'($signed(s[31:0]));
         default: v = rd;
      endcase
      if (w == 32) v[63:32] = 32'b0;
      return v;
   endfunction

   function automatic logic [7:0] model_be(input logic [1:0] sz, input int off);
      logic [15:0] m;
      m = (16'd1 << (1 << sz)) - 16'd1;
      return m[7:0] << off;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [1:0] sz);
      case (sz)
         2'd0:    return {8{wd[7:0]}};
         2'd1:    return {4{wd[15:0]}};
         2'd2:    return {2{wd[31:0]}};
         default: return wd;
      endcase
   endfunction

   task automatic run_op(input logic use_b, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic store, input logic [1:0] size, input logic uns,
                         input int stall, input logic [63:0] rdata, input logic [1:0] exp_err,
                         input logic [63:0] exp_data, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata);
      int n0, lat, exp_lat;
      bit seen;
      exp_lat = (exp_err != ERR_NONE) ? 1 : (store ? 2 + stall : 3 + stall);
      @(negedge clk);
      sel = use_b;
      req_addr = addr; req_wdata = wdata; req_is_store = store;
      req_size = size; req_unsigned = uns; req_valid = 1'b1;
      #1 check("req_ready", req_ready_s, 1'b1);
      exp_q.push_back({exp_err, exp_data});
      @(posedge clk); #1;
      req_valid = 1'b0;
      n0 = cyc;
      if (exp_err == ERR_NONE) begin
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("mem_valid_stall", mem_valid_s, 1'b1);
         end
         @(negedge clk);
         check("mem_valid", mem_valid_s, 1'b1);
         check("mem_addr", mem_addr_s, addr & (use_b ? ~32'h7 : ~32'h3));
         check("mem_we", mem_we_s, store);
         check("mem_be", mem_be_s, exp_be);
         if (store) check("mem_wdata", mem_wdata_s, exp_wdata);
         mem_ready = 1'b1;
         @(posedge clk); #1 mem_ready = 1'b0;
         if (!store) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = rdata;
            @(posedge clk); #1 mem_rvalid = 1'b0;
         end
      end
      seen = 1'b0;
      lat = 0;
      for (int i = 0; i < 16 && !seen; i++) begin
         @(negedge clk);
         if (exp_err != ERR_NONE) check("no_bus", mem_valid_s, 1'b0);
         if (resp_valid_s) begin
            seen = 1'b1;
            lat = cyc - n0 + 1;
         end
      end
      check("resp_seen", seen, 1'b1);
      if (seen) begin
         check("latency", lat, exp_lat);
         @(negedge clk);
         check("resp_pulse", resp_valid_s, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nresp;
      logic use_b, st, un;
      logic [1:0] sz;
      int off, stl;
      logic [31:0] ad;
      logic [63:0] wd, rd, ed, ew;
      logic [7:0] eb;

      sel = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_unsigned = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; req_addr = '0; req_wdata = '0;
      mem_rdata = '0; req_size = SIZE_B;

      #12;
      check("rst_req_ready", req_ready_a, 1'b1);
      check("rst_resp_valid", resp_valid_a, 1'b0);
      check("rst_resp_data", resp_data_a, 32'h0);
      check("rst_resp_error", resp_error_a, ERR_NONE);
      check("rst_mem_valid", mem_valid_a, 1'b0);
      check("rst_mem_we", mem_we_a, 1'b0);
      check("rst_mem_be", mem_be_a, 4'h0);
      check("rst_mem_addr", mem_addr_a, 32'h0);
      check("rst_mem_wdata", mem_wdata_a, 32'h0);
      check("rst_state", dbg_state_a, IDLE);
      check("rst_mem_valid_b", mem_valid_b, 1'b0);
      check("rst_mem_be_b", mem_be_b, 8'h0);
      @(negedge clk) rst = 1'b1;

      // 32-bit directed operations
      run_op(0, 32'h103, 64'hA5, 1, SIZE_B, 0, 0, 0, ERR_NONE, 0, 8'h08, 64'hA5A5A5A5);
      run_op(0, 32'h102, 0, 0, SIZE_H, 0, 3, 64'h80011234, ERR_NONE, 64'hFFFF8001, 8'h0C, 0);
      run_op(0, 32'h102, 0, 0, SIZE_H, 1, 3, 64'h80011234, ERR_NONE, 64'h00008001, 8'h0C, 0);
      run_op(0, 32'h102, 0, 0, SIZE_W, 0, 0, 0, ERR_MISALIGN, 0, 0, 0);
      run_op(0, 32'h100, 0, 0, SIZE_D, 0, 0, 0, ERR_SIZE, 0, 0, 0);
      run_op(0, 32'h002, 64'h1234BEEF, 1, SIZE_H, 0, 1, 0, ERR_NONE, 0, 8'h0C, 64'hBEEFBEEF);
      run_op(0, 32'h001, 0, 0, SIZE_B, 0, 0, 64'h00008000, ERR_NONE, 64'hFFFFFF80, 8'h02, 0);
      run_op(0, 32'h004, 0, 0, SIZE_W, 0, 2, 64'h87654321, ERR_NONE, 64'h87654321, 8'h0F, 0);
      run_op(0, 32'h005, 0, 0, SIZE_H, 0, 0, 0, ERR_MISALIGN, 0, 0, 0);

      // 64-bit directed operations
      run_op(1, 32'h1004, 0, 0, SIZE_W, 0, 0, 64'h8000_0000_0000_0000, ERR_NONE,
             64'hFFFF_FFFF_8000_0000, 8'hF0, 0);
      run_op(1, 32'h1000, 0, 0, SIZE_W, 1, 1, 64'h0000_0000_F000_0001, ERR_NONE,
             64'h0000_0000_F000_0001, 8'h0F, 0);
      run_op(1, 32'h1008, 64'h0123_4567_89AB_CDEF, 1, SIZE_D, 0, 0, 0, ERR_NONE, 0, 8'hFF,
             64'h0123_4567_89AB_CDEF);
      run_op(1, 32'h1004, 64'hFFFF_0000_DEAD_BEEF, 1, SIZE_W, 0, 0, 0, ERR_NONE, 0, 8'hF0,
             64'hDEAD_BEEF_DEAD_BEEF);
      run_op(1, 32'h1008, 0, 0, SIZE_D, 0, 0, 64'hFEDC_BA98_7654_3210, ERR_NONE,
             64'hFEDC_BA98_7654_3210, 8'hFF, 0);
      run_op(1, 32'h1004, 0, 0, SIZE_D, 0, 0, 0, ERR_MISALIGN, 0, 0, 0);
      run_op(1, 32'h1007, 0, 1'b0, SIZE_B, 1, 0, 64'hAB00_0000_0000_0000, ERR_NONE,
             64'h0000_0000_0000_00AB, 8'h80, 0);
      // mem_ready arrives in the same cycle the timeout would fire: completion wins
      run_op(1, 32'h2002, 64'h5A5A, 1, SIZE_H, 0, 3, 0, ERR_NONE, 0, 8'h0C, 64'h5A5A_5A5A_5A5A_5A5A);

      // bus timeout on the 64-bit unit, then a late read reply
      @(negedge clk);
      sel = 1'b1; req_addr = 32'h2000; req_size = SIZE_W; req_is_store = 1'b0;
      req_unsigned = 1'b0; req_valid = 1'b1;
      exp_q.push_back({ERR_TIMEOUT, 64'h0});
      @(posedge clk); #1 req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("tmo_mem_valid", mem_valid_s, 1'b1);
      end
      @(negedge clk);
      check("tmo_resp_valid", resp_valid_s, 1'b1);
      check("tmo_mem_drop", mem_valid_s, 1'b0);
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
      @(posedge clk); #1 mem_rvalid = 1'b0;
      nresp = 0;
      repeat (5) begin
         @(negedge clk);
         nresp += int'(resp_valid_s);
      end
      check("late_reply_ignored", nresp, 0);
      check("tmo_idle", req_ready_s, 1'b1);

      // reset while a load waits for read data
      @(negedge clk);
      sel = 1'b0; req_addr = 32'h40; req_size = SIZE_W; req_is_store = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk) mem_ready = 1'b1;
      @(posedge clk); #1 mem_ready = 1'b0;
      #2 check("in_wait_read", dbg_state_s, WAIT_READ);
      rst = 1'b0;
      #1 check("rst_async_ready", req_ready_s, 1'b1);
      check("rst_async_state", dbg_state_s, IDLE);

      // reset while a store is stalled on the bus
      @(negedge clk);
      rst = 1'b1; sel = 1'b1; req_addr = 32'h3000; req_size = SIZE_D; req_is_store = 1'b1;
      req_wdata = 64'hCAFE; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk) check("issue_mem_valid", mem_valid_s, 1'b1);
      #1 rst = 1'b0;
      #1 check("rst_async_mem_valid", mem_valid_s, 1'b0);
      check("rst_async_mem_be", mem_be_s, 8'h0);
      @(negedge clk) rst = 1'b1;

      run_op(1, 32'h3000, 64'h0BAD_F00D_1234_5678, 1, SIZE_D, 0, 0, 0, ERR_NONE, 0, 8'hFF,
             64'h0BAD_F00D_1234_5678);
      run_op(0, 32'h042, 0, 0, SIZE_B, 0, 1, 64'h00AA_0000, ERR_NONE, 64'hFFFF_FFAA, 8'h04, 0);

      // randomised aligned traffic on both widths
      for (int k = 0; k < 24; k++) begin
         use_b = k[0];
         sz  = use_b ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
         off = $urandom_range(0, use_b ? 7 : 3) & ~((1 << sz) - 1);
         ad  = ($urandom & 32'hFFFF_FFF8) | 32'(off);
         st  = 1'($urandom_range(0, 1));
         un  = 1'($urandom_range(0, 1));
         stl = $urandom_range(0, 2);
         wd  = {$urandom, $urandom};
         rd  = {$urandom, $urandom};
         eb  = model_be(sz, off);
         ew  = model_wdata(wd, sz);
         ed  = st ? 64'h0 : model_load(rd, off, sz, un, use_b ? 64 : 32);
         if (!use_b) ew[63:32] = 32'h0;
         run_op(use_b, ad, wd, st, sz, un, stl, rd, ERR_NONE, ed, eb, ew);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the processor datapath. It accepts one memory operation at a time from the core control FSM and checks alignment and size. It performs byte-lane steering and sign/zero extension, and drives a valid/ready memory port with byte enables. It replaces ad-hoc address/write-enable handling in the core. It adds store data steering, a 64-bit mode, bus backpressure and a bus timeout.

## Interface
Parameters:
- WORD_SIZE, 32, datapath width; legal values 32 or 64
- ADDR_WIDTH, 32, byte address width
- TIMEOUT_CYCLES, 255, cycles allowed in ISSUE+WAIT_READ before a timeout error; 0 disables the timeout

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  active-low, asynchronous reset
- req_valid  in  1  operation request
- req_ready  out  1  high in IDLE only
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  WORD_SIZE  store data, right-aligned
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_unsigned  in  1  zero-extend a load (LBU/LHU/LWU)
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_data  out  WORD_SIZE  extended load data; 0 for stores and errors
- resp_error  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size
- mem_valid  out  1  bus request, held until mem_ready
- mem_ready  in  1  bus accepts request
- mem_addr  out  ADDR_WIDTH  word-aligned address (low log2(WORD_SIZE/8) bits zero)
- mem_we  out  1  store
- mem_be  out  WORD_SIZE/8  byte enables
- mem_wdata  out  WORD_SIZE  lane-steered store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_SIZE  full word read

## Operation
- States: IDLE, ISSUE, WAIT_READ, RESPOND.
- IDLE: req_ready=1. On req_valid, register all req_* fields, then check them:
  - illegal size (11 with WORD_SIZE=32) -> RESPOND, error 11.
  - address not a multiple of the access size -> RESPOND, error 01.
  - In both error cases no bus transaction is issued.
  - Otherwise -> ISSUE.
- ISSUE: mem_valid=1; mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_ready. On mem_ready: a store goes to RESPOND; a load goes to WAIT_READ.
- WAIT_READ: on mem_rvalid, register the extracted data -> RESPOND.
- RESPOND: resp_valid=1 for exactly one cycle, then IDLE.
- Lanes are little-endian: byte offset k maps to mem_rdata/mem_wdata bits [8k+7:8k].
- mem_be is the size mask (1, 3, F, FF) shifted left by the byte offset.
- Store data is replicated across lanes (byte to every lane, half to every half-lane), so mem_wdata is independent of the offset.
- Load extract: shift right by 8*offset, then sign- or zero-extend from 8/16/32 bits. Dword loads and WORD_SIZE-wide word loads pass through unchanged.
- Timeout:
  - The counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_READ.
  - On reaching TIMEOUT_CYCLES without completion: -> RESPOND with error 10, and mem_valid drops.
  - If completion and expiry occur in the same cycle, completion wins.
- mem_rvalid outside WAIT_READ (e.g. a late reply after a timeout) is ignored.
- Reset mid-operation: the unit returns to IDLE immediately and mem_valid deasserts asynchronously. Any in-flight bus transaction is abandoned.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=00, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- All outputs are registered or decoded from the registered state only; there are no combinational paths from req_* to mem_*.
- Request accepted at cycle N:
  - ISSUE is at N+1.
  - Store with mem_ready at N+1: resp_valid at N+2.
  - Load with mem_ready at N+1 and mem_rvalid at N+2: resp_valid at N+3.
  - Error detected at accept: resp_valid at N+1.
- Minimum throughput: one store per 3 cycles, one load per 4 cycles.

## Structure
- Package lsu_pkg holds:
  - size encodings (SIZE_B/H/W/D)
  - error codes (ERR_NONE/MISALIGN/TIMEOUT/SIZE)
  - the state enum
- Sub-module lane_extract: combinational shift plus sign/zero extension, parametrised by WORD_SIZE. It is reused by the core's debug read path.
- Alignment check and byte-enable generation stay inline.

## Test plan
- WORD_SIZE=32, store byte 0xA5 at addr 0x103, mem_ready immediately -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, resp_valid 2 cycles after accept with error 00.
- Load half signed at 0x102, mem_rdata=0x8001_1234 after 3 mem_ready stall cycles -> resp_data=0xFFFF8001. The same load with req_unsigned=1 -> 0x00008001.
- Load word at 0x102 -> resp_error=01, resp_valid at N+1, mem_valid never asserted. Request dword with WORD_SIZE=32 -> resp_error=11.
- TIMEOUT_CYCLES=4, mem_ready held low -> mem_valid high for 4 cycles, then resp_error=10. A subsequent mem_rvalid pulse causes no response.
- WORD_SIZE=64, load word signed at 0x1004, mem_rdata=0x8000_0000_0000_0000 -> resp_data=0xFFFFFFFF80000000, mem_be=8'hF0.
- Assert rst low while in WAIT_READ -> mem_valid=0 and req_ready=1 without waiting for clk. The next request then completes normally.
